// File: rtl/hazard_pkg.sv
// hazard_pkg: shared scoreboard entry type, Tnew constants and address-width helper
package hazard_pkg;

    localparam int SB_AW = 8;
    localparam int SB_TW = 4;

    typedef enum logic [SB_TW-1:0] {T0, T1, T2} tval_e;

    typedef struct packed {
        logic             valid;
        logic [SB_AW-1:0] a3;
        logic [SB_TW-1:0] tnew;
    } sb_entry_t;

    function automatic int addr_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hazard_md_counter.sv
// hazard_md_counter: multiply/divide occupancy counter driving md_busy
module hazard_md_counter #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic div,
    output logic busy
);

    localparam int MAXL = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int CNW  = $clog2(MAXL + 1);

    logic [CNW-1:0] md_cnt;

    // load the latency of the issuing operation, otherwise count down to idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            md_cnt <= '0;
        else if (load)
            md_cnt <= div ? CNW'(DIV_LAT) : CNW'(MULT_LAT);
        else if (md_cnt != '0)
            md_cnt <= md_cnt - 1'b1;
    end

    assign busy = (md_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage stall/forward control from an in-flight destination scoreboard
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int DW       = 32,
    parameter int NREG     = 32,
    parameter int NSTG     = 3,
    parameter int TW       = 2,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CW       = 32,
    localparam int AW      = addr_width(NREG)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [AW-1:0]      id_a1,
    input  logic [AW-1:0]      id_a2,
    input  logic               id_use1,
    input  logic               id_use2,
    input  logic [TW-1:0]      id_tuse1,
    input  logic [TW-1:0]      id_tuse2,
    input  logic [AW-1:0]      id_a3,
    input  logic [TW-1:0]      id_tnew,
    input  logic               id_md_use,
    input  logic               id_md_start,
    input  logic               id_md_div,
    input  logic [DW-1:0]      id_rd1,
    input  logic [DW-1:0]      id_rd2,
    input  logic [NSTG*DW-1:0] stg_wd,
    output logic [DW-1:0]      id_rd1_fwd,
    output logic [DW-1:0]      id_rd2_fwd,
    output logic               id_fwd1_pend,
    output logic               id_fwd2_pend,
    output logic               stall,
    output logic               stall_raw,
    output logic               stall_md,
    output logic               md_busy,
    output logic [CW-1:0]      stall_cnt
);

    sb_entry_t       sb [NSTG];
    logic [AW-1:0]   src_a [2];
    logic            src_use [2];
    logic [TW-1:0]   src_tuse [2];
    logic [DW-1:0]   src_rd [2];
    logic [NSTG-1:0] mt [2];
    logic            hit [2];
    logic            near_rdy [2];
    logic [DW-1:0]   near_wd [2];
    logic [DW-1:0]   fwd [2];
    logic            pend [2];

    assign src_a[0]    = id_a1;
    assign src_a[1]    = id_a2;
    assign src_use[0]  = id_use1;
    assign src_use[1]  = id_use2;
    assign src_tuse[0] = id_tuse1;
    assign src_tuse[1] = id_tuse2;
    assign src_rd[0]   = id_rd1;
    assign src_rd[1]   = id_rd2;

    // per-source, per-stage producer match; register 0 never matches
    always_comb begin
        for (int x = 0; x < 2; x++) begin
            mt[x] = '0;
            for (int k = 0; k < NSTG; k++)
                mt[x][k] = sb[k].valid && (sb[k].a3 != '0) &&
                           (sb[k].a3 == SB_AW'(src_a[x])) && src_use[x];
        end
    end

    // RAW stall over every matching stage, and nearest-producer selection for forwarding
    always_comb begin
        stall_raw = 1'b0;
        for (int x = 0; x < 2; x++) begin
            hit[x]      = 1'b0;
            near_rdy[x] = 1'b0;
            near_wd[x]  = '0;
            for (int k = NSTG - 1; k >= 0; k--) begin
                if (mt[x][k]) begin
                    hit[x]      = 1'b1;
                    near_rdy[x] = (sb[k].tnew == T0);
                    near_wd[x]  = stg_wd[k*DW +: DW];
                end
                if (mt[x][k] && (SB_TW'(src_tuse[x]) < sb[k].tnew))
                    stall_raw = 1'b1;
            end
        end
    end

    assign stall_md = id_valid && id_md_use && md_busy;
    assign stall    = stall_raw | stall_md;

    // operand select: zero register, ready producer, or register file with pending flag
    always_comb begin
        for (int x = 0; x < 2; x++) begin
            fwd[x]  = (src_a[x] == '0) ? '0 : (hit[x] && near_rdy[x]) ? near_wd[x] : src_rd[x];
            pend[x] = (src_a[x] != '0) && hit[x] && !near_rdy[x] && !stall;
        end
    end

    assign id_rd1_fwd   = fwd[0];
    assign id_rd2_fwd   = fwd[1];
    assign id_fwd1_pend = pend[0];
    assign id_fwd2_pend = pend[1];

    // scoreboard always advances; a stalled or empty ID slot enters as a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSTG; k++)
                sb[k] <= '0;
        end else begin
            sb[0] <= (stall || !id_valid) ? '0 :
                     '{valid: 1'b1, a3: SB_AW'(id_a3), tnew: SB_TW'(id_tnew)};
            for (int k = 1; k < NSTG; k++)
                sb[k] <= '{valid: sb[k-1].valid, a3: sb[k-1].a3,
                           tnew: (sb[k-1].tnew == T0) ? sb[k-1].tnew : sb[k-1].tnew - T1};
        end
    end

    hazard_md_counter #(
        .MULT_LAT(MULT_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_md (
        .clk  (clk),
        .rst_n(rst_n),
        .load (id_valid && id_md_start && !stall),
        .div  (id_md_div),
        .busy (md_busy)
    );

    // saturating stall-cycle performance counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised successor to the combinational hazard/forwarding controller. It keeps its own scoreboard of in-flight destination registers and their remaining Tnew, indexed by pipeline stage, and decides ID-stage stalls and ID-stage forwarding from that state. It also tracks multiply/divide occupancy with an internal latency counter instead of taking an external busy flag, and it counts stall cycles for performance monitoring. The block sits beside the ID stage and drives PC/IF_ID enables and the ID_EX bubble.

## Interface
Parameters:
- `DW`, 32, datapath width
- `NREG`, 32, architectural register count; `AW = $clog2(NREG)`
- `NSTG`, 3, tracked stages after ID (index 0 = EX, `NSTG-1` = WB)
- `TW`, 2, width of Tuse/Tnew fields
- `MULT_LAT`, 5, multiply busy cycles
- `DIV_LAT`, 10, divide busy cycles
- `CW`, 32, stall counter width

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `id_valid`  in  1  ID holds a real instruction
- `id_a1`, `id_a2`  in  AW  source register numbers
- `id_use1`, `id_use2`  in  1  the source is actually read
- `id_tuse1`, `id_tuse2`  in  TW  cycles from ID until the value is needed
- `id_a3`  in  AW  destination register (0 = none)
- `id_tnew`  in  TW  cycles, counted at EX, until the result exists
- `id_md_use`  in  1  the instruction touches HI/LO or the MDU
- `id_md_start`  in  1  the instruction starts an MDU operation
- `id_md_div`  in  1  1 = divide, 0 = multiply (qualified by `id_md_start`)
- `id_rd1`, `id_rd2`  in  DW  register-file read data
- `stg_wd`  in  NSTG*DW  result data of stage k at bits `[k*DW +: DW]`
- `id_rd1_fwd`, `id_rd2_fwd`  out  DW  forwarded operands
- `id_fwd1_pend`, `id_fwd2_pend`  out  1  nearest producer is not ready yet; a later stage must re-forward
- `stall`  out  1  freeze PC and IF_ID, insert a bubble into ID_EX
- `stall_raw`, `stall_md`  out  1  stall cause
- `md_busy`  out  1  MDU counter nonzero
- `stall_cnt`  out  CW  saturating count of stall cycles

## Operation
- Scoreboard: `sb[0..NSTG-1]`, each entry holds {valid, a3, tnew}. The pipeline always advances.
  - `sb[0] <=` bubble if `stall` or `!id_valid`, else {1, `id_a3`, `id_tnew`}.
  - `sb[k] <= sb[k-1]` with tnew decremented, saturating at 0.
- Match rule: `match(k,x)` = `sb[k].valid` && `sb[k].a3 != 0` && `sb[k].a3 == id_ax` && `id_usex`.
- RAW stall: any k with `match(k,x)` and `id_tusex < sb[k].tnew` sets `stall_raw`.
- MDU stall: `stall_md = id_valid && id_md_use && md_busy`.
- `stall = stall_raw | stall_md`.
- Forwarding, source x:
  - If `id_ax == 0`, output 0.
  - Otherwise take the smallest k with `match(k,x)`. Nearer stages shadow farther ones.
  - If that entry has tnew 0, output `stg_wd[k]`.
  - If that entry has tnew > 0 and no stall, output `id_rdx` and assert `id_fwdx_pend`.
  - If no stage matches, output `id_rdx`.
- MDU counter `md_cnt`:
  - Load `id_md_div ? DIV_LAT : MULT_LAT` when `id_valid && id_md_start && !stall`.
  - Otherwise decrement while nonzero.
  - `md_busy = (md_cnt != 0)`.
  - A start while busy cannot issue, because the start instruction itself has `id_md_use`.
- `stall_cnt`: increments each cycle `stall` is high and saturates at `2^CW-1`.

## Timing
- `stall`, forwards, pend flags and cause flags are combinational from the ID inputs and registered state, with zero-cycle latency.
- Scoreboard, `md_cnt` and `stall_cnt` update on the rising `clk` edge.
- Reset (async assert, sync release): all sb entries invalid, `md_cnt = 0`, `stall_cnt = 0`.
  - Outputs under reset: `stall = 0`, `md_busy = 0`, `stall_cnt = 0`, pend flags 0.
  - `id_rdx_fwd` passes `id_rdx` through (0 for register 0).
- Reset mid-divide: `md_busy` drops immediately and no residual stall remains.
- A stalled cycle inserts exactly one bubble into `sb[0]`; the ID instruction is re-evaluated the next cycle against the advanced scoreboard.
- `stall` and `md_start` in the same cycle: the counter is not loaded.
- tnew never wraps below 0.
- The MDU counter loads on the cycle the start instruction leaves ID. The next ID instruction sees `md_busy` for exactly LAT cycles.

## Structure
- Package `hazard_pkg`:
  - typedef `sb_entry_t` {valid, a3, tnew}
  - constants `T0`, `T1`, `T2`
  - `AW` derivation helper
- Sub-module `hazard_md_counter`: the load/decrement counter and the `md_busy` output. Scoreboard shift, match and forward logic stay in the top.

## Test plan
- lw $1 (tnew 2) then beq $1 (tuse 0): `stall` high 2 cycles, `stall_raw` = 1; third cycle `id_rd1_fwd = stg_wd[2]` (e.g. 0x1234), `stall` = 0.
- addu $3 (tnew 0) then addu $3 (tuse 1), with EX and MEM both writing $3 (0xAAAA in EX, 0xBBBB in MEM): `id_rd1_fwd = 0xAAAA` and no stall.
- lw $5 then addu using $5 (tuse 1): one stall; next cycle no stall, `id_fwd1_pend = 1`, `id_rd1_fwd = id_rd1`.
- Writes to $0 with tnew 2 followed by readers of $0: no stall, forward value 0.
- div (DIV_LAT = 10) then mfhi: `stall_md` high exactly 10 cycles, `stall_cnt` = 10. Repeat with `rst_n` pulsed low at cycle 4: `md_busy` = 0 and `stall` = 0 immediately.
- With CW = 4, force 20 consecutive stalls: `stall_cnt` saturates at 15 and holds.
